// File: rtl/equiv_pkg.sv
// rtl/equiv_pkg.sv - Shared state encoding and lane-delay helpers for the equivalence monitor
package equiv_pkg;

   typedef enum logic [1:0] {
      ST_WARM  = 2'd0,
      ST_CHECK = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   localparam int LANE_IDX_W = 3;
   localparam int DLY_W      = 3;
   localparam int MAX_LANES  = 8;

   // Per-lane delay field out of the packed parameter, zero-extended to MAX_LANES fields.
   function automatic int lane_dly(input logic [MAX_LANES*DLY_W-1:0] packed_dly, input int lane);
      return int'(packed_dly[lane*DLY_W +: DLY_W]);
   endfunction

endpackage

// File: rtl/equiv_delay_line.sv
// rtl/equiv_delay_line.sv - Fixed-depth data+valid shift register; depth 0 is a pass-through
module equiv_delay_line #(
   parameter int WIDTH = 91,
   parameter int DEPTH = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_vld,
   output logic [WIDTH-1:0] out_data,
   output logic             out_vld
);

   // One stage is always declared so the depth-0 case elaborates; it is dead logic then.
   localparam int N = (DEPTH == 0) ? 1 : DEPTH;

   logic [WIDTH-1:0] data_q [N];
   logic [N-1:0]     vld_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            data_q[i] <= '0;
         end
         vld_q <= '0;
      end else begin
         data_q[0] <= in_data;
         vld_q[0]  <= in_vld;
         for (int i = 1; i < N; i++) begin
            data_q[i] <= data_q[i-1];
            vld_q[i]  <= vld_q[i-1];
         end
      end
   end

   assign out_data = (DEPTH == 0) ? in_data : data_q[N-1];
   assign out_vld  = (DEPTH == 0) ? in_vld  : vld_q[N-1];

endmodule

// File: rtl/equiv_miter_monitor.sv
// rtl/equiv_miter_monitor.sv - Multi-lane sequential equivalence monitor against golden lane 0
module equiv_miter_monitor
   import equiv_pkg::*;
#(
   parameter int                       WIDTH    = 91,
   parameter int                       NUM_DUT  = 2,
   parameter logic [NUM_DUT*DLY_W-1:0] LANE_DLY = '0,
   parameter int                       WARMUP   = 2,
   parameter int                       CNT_W    = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     smp_vld,
   input  logic [NUM_DUT*WIDTH-1:0] y_in,
   input  logic [NUM_DUT-1:0]       lane_mask,
   input  logic                     stop_on_fail,
   output logic                     fail,
   output logic [NUM_DUT-1:0]       fail_vec,
   output logic [CNT_W-1:0]         mism_cnt,
   output logic [CNT_W-1:0]         smp_cnt,
   output logic [CNT_W-1:0]         first_idx,
   output logic [LANE_IDX_W-1:0]    first_lane,
   output logic [WIDTH-1:0]         first_diff,
   output logic [1:0]               state
);

   localparam int                 EXT_W   = MAX_LANES * DLY_W;
   localparam logic [EXT_W-1:0]   DLY_EXT = EXT_W'(LANE_DLY);
   localparam int                 WARM_W  = (WARMUP < 2) ? 1 : $clog2(WARMUP);

   logic [NUM_DUT-1:0][WIDTH-1:0] al_data;
   logic [NUM_DUT-1:0]            al_vld;

   for (genvar i = 0; i < NUM_DUT; i++) begin : g_lane
      equiv_delay_line #(
         .WIDTH (WIDTH),
         .DEPTH (lane_dly(DLY_EXT, i))
      ) u_dly (
         .clk      (clk),
         .rst_n    (rst_n),
         .in_data  (y_in[i*WIDTH +: WIDTH]),
         .in_vld   (smp_vld),
         .out_data (al_data[i]),
         .out_vld  (al_vld[i])
      );
   end

   logic [NUM_DUT-1:0]    mism;
   logic [LANE_IDX_W-1:0] low_lane;
   logic [WIDTH-1:0]      low_diff;

   // Lane 0 never mismatches itself; descending scan leaves the lowest failing lane selected.
   always_comb begin
      mism     = '0;
      low_lane = '0;
      low_diff = '0;
      for (int i = 0; i < NUM_DUT; i++) begin
         mism[i] = (i != 0) && al_vld[0] && al_vld[i] && !lane_mask[i] && (al_data[i] != al_data[0]);
      end
      for (int i = NUM_DUT - 1; i > 0; i--) begin
         if (mism[i]) begin
            low_lane = LANE_IDX_W'(i);
            low_diff = al_data[0] ^ al_data[i];
         end
      end
   end

   state_t                state_q, state_d;
   logic [WARM_W-1:0]     warm_q, warm_d;
   logic [CNT_W-1:0]      smp_d, mism_d, fidx_d;
   logic                  fail_d;
   logic [NUM_DUT-1:0]    fvec_d;
   logic [LANE_IDX_W-1:0] flane_d;
   logic [WIDTH-1:0]      fdiff_d;

   always_comb begin
      state_d = state_q;
      warm_d  = warm_q;
      smp_d   = smp_cnt;
      mism_d  = mism_cnt;
      fidx_d  = first_idx;
      fail_d  = fail;
      fvec_d  = fail_vec;
      flane_d = first_lane;
      fdiff_d = first_diff;
      case (state_q)
         ST_WARM: begin
            if (al_vld[0]) begin
               if (warm_q == WARM_W'(WARMUP - 1)) state_d = ST_CHECK;
               else                               warm_d  = warm_q + WARM_W'(1);
            end
         end
         ST_CHECK: begin
            if (al_vld[0]) begin
               smp_d = (smp_cnt == '1) ? smp_cnt : smp_cnt + CNT_W'(1);
               if (|mism) begin
                  mism_d = (mism_cnt == '1) ? mism_cnt : mism_cnt + CNT_W'(1);
                  fail_d = 1'b1;
                  fvec_d = fail_vec | mism;
                  if (!fail) begin
                     fidx_d  = smp_cnt;
                     flane_d = low_lane;
                     fdiff_d = low_diff;
                  end
                  if (stop_on_fail) state_d = ST_HALT;
               end
            end
         end
         default: state_d = state_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= (WARMUP == 0) ? ST_CHECK : ST_WARM;
         warm_q     <= '0;
         smp_cnt    <= '0;
         mism_cnt   <= '0;
         first_idx  <= '0;
         fail       <= 1'b0;
         fail_vec   <= '0;
         first_lane <= '0;
         first_diff <= '0;
      end else begin
         state_q    <= state_d;
         warm_q     <= warm_d;
         smp_cnt    <= smp_d;
         mism_cnt   <= mism_d;
         first_idx  <= fidx_d;
         fail       <= fail_d;
         fail_vec   <= fvec_d;
         first_lane <= flane_d;
         first_diff <= fdiff_d;
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_equiv_miter_monitor.sv
// tb/tb_equiv_miter_monitor.sv - Randomised self-checking bench for equiv_miter_monitor
module tb_equiv_miter_monitor;

   localparam int         W      = 91;
   localparam int         N      = 3;
   localparam int         WARMUP = 2;
   localparam logic [8:0] DLY_D  = 9'b000_011_000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst_n = 1'b0;
   logic           smp_vld = 1'b0;
   logic           stop_on_fail = 1'b0;
   logic [N*W-1:0] y_in = '0;
   logic [N-1:0]   lane_mask = '0;

   logic           fail_m, fail_d;
   logic [N-1:0]   fvec_m, fvec_d;
   logic [15:0]    mism_m, smp_m, fidx_m;
   logic [3:0]     mism_d, smp_d, fidx_d;
   logic [2:0]     flane_m, flane_d;
   logic [W-1:0]   fdiff_m, fdiff_d;
   logic [1:0]     st_m, st_d;

   equiv_miter_monitor #(.WIDTH(W), .NUM_DUT(N), .LANE_DLY(9'd0), .WARMUP(WARMUP), .CNT_W(16)) u_main (
      .clk(clk), .rst_n(rst_n), .smp_vld(smp_vld), .y_in(y_in), .lane_mask(lane_mask),
      .stop_on_fail(stop_on_fail), .fail(fail_m), .fail_vec(fvec_m), .mism_cnt(mism_m),
      .smp_cnt(smp_m), .first_idx(fidx_m), .first_lane(flane_m), .first_diff(fdiff_m), .state(st_m));

   equiv_miter_monitor #(.WIDTH(W), .NUM_DUT(N), .LANE_DLY(DLY_D), .WARMUP(WARMUP), .CNT_W(4)) u_dly (
      .clk(clk), .rst_n(rst_n), .smp_vld(smp_vld), .y_in(y_in), .lane_mask(lane_mask),
      .stop_on_fail(stop_on_fail), .fail(fail_d), .fail_vec(fvec_d), .mism_cnt(mism_d),
      .smp_cnt(smp_d), .first_idx(fidx_d), .first_lane(flane_d), .first_diff(fdiff_d), .state(st_d));

   // Reference model: k=0 is u_main, k=1 is u_dly. States 0/1/2 = warm/check/halt.
   typedef struct {
      bit             vld;
      logic [N*W-1:0] y;
   } smp_t;

   smp_t         hist[$];
   int           m_state[2], m_warm[2], m_smp[2], m_mism[2], m_fidx[2], m_flane[2];
   bit           m_fail[2];
   bit [N-1:0]   m_fvec[2];
   logic [W-1:0] m_fdiff[2];
   int           n_pass = 0, n_fail = 0, n_total = 0;

   function automatic int get_dly(input int k, input int l);
      return (k == 1 && l == 1) ? 3 : 0;
   endfunction

   function automatic int cmax(input int k);
      return (k == 0) ? 65535 : 15;
   endfunction

   function automatic logic [W-1:0] rnd();
      logic [95:0] t;
      t = {$urandom(), $urandom(), $urandom()};
      return t[W-1:0];
   endfunction

   task automatic model_step();
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            m_state[k] = 0; m_warm[k] = 0; m_smp[k] = 0; m_mism[k] = 0;
            m_fidx[k] = 0; m_flane[k] = 0; m_fail[k] = 0; m_fvec[k] = '0; m_fdiff[k] = '0;
         end
         hist.delete();
         return;
      end
      for (int k = 0; k < 2; k++) begin
         bit           av[N];
         logic [W-1:0] ad[N];
         bit [N-1:0]   bad;
         int           low;
         for (int l = 0; l < N; l++) begin
            int d;
            d = get_dly(k, l);
            if (d == 0) begin
               av[l] = smp_vld; ad[l] = y_in[l*W +: W];
            end else if (hist.size() >= d) begin
               av[l] = hist[hist.size()-d].vld; ad[l] = hist[hist.size()-d].y[l*W +: W];
            end else begin
               av[l] = 1'b0; ad[l] = '0;
            end
         end
         if (!av[0] || m_state[k] == 2) continue;
         if (m_state[k] == 0) begin
            m_warm[k]++;
            if (m_warm[k] == WARMUP) m_state[k] = 1;
            continue;
         end
         bad = '0;
         low = 0;
         for (int l = N - 1; l >= 1; l--) begin
            if (av[l] && !lane_mask[l] && ad[l] !== ad[0]) begin
               bad[l] = 1'b1;
               low = l;
            end
         end
         if (bad != 0) begin
            if (!m_fail[k]) begin
               m_fidx[k]  = m_smp[k];
               m_flane[k] = low;
               m_fdiff[k] = ad[0] ^ ad[low];
            end
            m_fail[k] = 1'b1;
            m_fvec[k] |= bad;
            m_mism[k] = (m_mism[k] < cmax(k)) ? m_mism[k] + 1 : cmax(k);
            if (stop_on_fail) m_state[k] = 2;
         end
         m_smp[k] = (m_smp[k] < cmax(k)) ? m_smp[k] + 1 : cmax(k);
      end
      hist.push_back('{smp_vld, y_in});
      if (hist.size() > 8) void'(hist.pop_front());
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("main.fail", fail_m, m_fail[0]);      chk("dly.fail", fail_d, m_fail[1]);
      chk("main.fail_vec", fvec_m, m_fvec[0]);  chk("dly.fail_vec", fvec_d, m_fvec[1]);
      chk("main.mism_cnt", mism_m, m_mism[0]);  chk("dly.mism_cnt", mism_d, m_mism[1]);
      chk("main.smp_cnt", smp_m, m_smp[0]);     chk("dly.smp_cnt", smp_d, m_smp[1]);
      chk("main.first_idx", fidx_m, m_fidx[0]); chk("dly.first_idx", fidx_d, m_fidx[1]);
      chk("main.first_lane", flane_m, m_flane[0]);
      chk("dly.first_lane", flane_d, m_flane[1]);
      chk("main.first_diff", fdiff_m, m_fdiff[0]);
      chk("dly.first_diff", fdiff_d, m_fdiff[1]);
      chk("main.state", st_m, m_state[0]);      chk("dly.state", st_d, m_state[1]);
   endtask

   task automatic drive(input bit v, input logic [W-1:0] l0, input logic [W-1:0] l1, input logic [W-1:0] l2);
      smp_vld = v;
      y_in    = {l2, l1, l0};
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive(1'b0, '0, '0, '0);
      step();
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      int           nv;
      bit           v;
      logic [W-1:0] d, x, flip;
      logic [W-1:0] g[$];

      // Reset state
      do_reset();
      chk("rst.fail", fail_m, 0);   chk("rst.smp_cnt", smp_m, 0);  chk("rst.state", st_m, 0);
      chk("rst.dly_fail", fail_d, 0); chk("rst.dly_state", st_d, 0);

      // Equal lanes, 20 valid samples with gaps
      lane_mask = '0; stop_on_fail = 1'b0; nv = 0;
      while (nv < 20) begin
         v = ($urandom_range(0, 3) != 0);
         d = rnd();
         drive(v, d, d, d);
         step();
         if (v) nv++;
      end
      drive(1'b0, '0, '0, '0);
      repeat (4) step();
      chk("eq.fail", fail_m, 0); chk("eq.smp_cnt", smp_m, 18); chk("eq.state", st_m, 1);

      // Lane 1 runs 3 samples ahead of golden
      do_reset();
      g.delete();
      for (int i = 0; i < 13; i++) g.push_back(rnd());
      for (int t = 0; t < 10; t++) begin
         drive(1'b1, g[t], g[t+3], g[t]);
         step();
      end
      chk("dly.aligned_fail", fail_d, 0); chk("dly.aligned_smp", smp_d, 8);
      chk("nodly.fail", fail_m, 1); chk("nodly.first_lane", flane_m, 1); chk("nodly.first_idx", fidx_m, 0);

      // Lane 2 bit 5 flipped on checked sample 4, stop on fail
      do_reset();
      stop_on_fail = 1'b1;
      flip = '0; flip[5] = 1'b1;
      for (int n = 0; n < 10; n++) begin
         d = rnd();
         drive(1'b1, d, d, (n == 6) ? (d ^ flip) : d);
         step();
         if (n == 5) chk("halt.fail_before", fail_m, 0);
         if (n == 6) chk("halt.fail_after", fail_m, 1);
      end
      chk("halt.first_idx", fidx_m, 4); chk("halt.first_lane", flane_m, 2);
      chk("halt.first_diff", fdiff_m, 'h20); chk("halt.state", st_m, 2);
      chk("halt.smp_cnt", smp_m, 5); chk("halt.mism_cnt", mism_m, 1);

      // Lanes 1 and 2 together, then three more lane-1 failures
      do_reset();
      stop_on_fail = 1'b0;
      x = rnd() | W'(1);
      for (int n = 0; n < 9; n++) begin
         d = rnd();
         if (n == 3)                drive(1'b1, d, d ^ x, d ^ (rnd() | W'(2)));
         else if (n > 3 && n < 7)   drive(1'b1, d, d ^ x, d);
         else                       drive(1'b1, d, d, d);
         step();
      end
      chk("multi.fail_vec", fvec_m, 3'b110); chk("multi.first_lane", flane_m, 1);
      chk("multi.mism_cnt", mism_m, 4); chk("multi.first_idx", fidx_m, 1);
      chk("multi.first_diff", fdiff_m, x);

      // Masked lane 2, then unmask
      do_reset();
      lane_mask = 3'b100;
      for (int n = 0; n < 8; n++) begin
         d = rnd();
         drive(1'b1, d, d, d ^ x);
         step();
      end
      chk("mask.fail", fail_m, 0); chk("mask.smp_cnt", smp_m, 6);
      lane_mask = 3'b000;
      d = rnd();
      drive(1'b1, d, d, d ^ x);
      step();
      chk("unmask.fail", fail_m, 1); chk("unmask.fail_vec", fvec_m, 3'b100);
      chk("unmask.first_idx", fidx_m, 6);

      // Saturation of the 4-bit counters, then a one-cycle reset mid-run
      do_reset();
      for (int n = 0; n < 22; n++) begin
         d = rnd();
         drive(1'b1, d, d, d ^ x);
         step();
      end
      chk("sat.dly_mism", mism_d, 15); chk("sat.dly_smp", smp_d, 15);
      chk("sat.main_mism", mism_m, 20); chk("sat.main_smp", smp_m, 20);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("midrst.fail", fail_m, 0); chk("midrst.fail_vec", fvec_m, 0); chk("midrst.mism", mism_m, 0);
      chk("midrst.smp", smp_m, 0); chk("midrst.idx", fidx_m, 0); chk("midrst.lane", flane_m, 0);
      chk("midrst.diff", fdiff_m, 0); chk("midrst.state", st_m, 0); chk("midrst.dly_state", st_d, 0);
      chk("midrst.dly_mism", mism_d, 0);

      // Random soak against the model
      for (int c = 0; c < 400; c++) begin
         rst_n        = ($urandom_range(0, 39) != 0);
         lane_mask    = N'($urandom());
         stop_on_fail = ($urandom_range(0, 7) == 0);
         d = rnd();
         drive($urandom_range(0, 3) != 0, d,
               ($urandom_range(0, 5) == 0) ? (d ^ rnd()) : d,
               ($urandom_range(0, 5) == 0) ? (d ^ rnd()) : d);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/equiv_miter_monitor.md
Name: equiv_miter_monitor

Overview:
- Parametrised sequential equivalence monitor for fuzz-generated proof harnesses.
- Compares NUM_DUT output buses against lane 0, which is the golden lane. Each lane first passes through its own alignment delay, so designs of different pipeline latency can be compared.
- Adds warm-up masking, per-lane sticky mismatch flags, a saturating mismatch counter, first-failure capture and a stop-on-fail mode.
- Sits in the top-level proof wrapper beside the DUT instances. It replaces the bare per-clock equality assertion and drives the formal assertion and simulation log.

Parameters:
- WIDTH, 91, width of each DUT output bus.
- NUM_DUT, 2, number of lanes (2..8); lane 0 is golden.
- LANE_DLY, 0, packed 3 bits per lane (NUM_DUT*3 bits); alignment delay of lane i, 0..7 cycles.
- WARMUP, 2, number of valid aligned samples ignored after reset.
- CNT_W, 16, width of the sample and mismatch counters.

Ports:
- clk  in  1  sole clock; all logic updates on posedge.
- rst_n  in  1  synchronous reset, active-low.
- smp_vld  in  1  current y_in is a sample; counted and delayed only when high.
- y_in  in  NUM_DUT*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH].
- lane_mask  in  NUM_DUT  1 = exclude the lane from comparison; bit 0 is ignored.
- stop_on_fail  in  1  1 = freeze on first failure; 0 = keep counting.
- fail  out  1  sticky; any unmasked lane mismatched after warm-up.
- fail_vec  out  NUM_DUT  sticky per-lane mismatch flags; bit 0 is always 0.
- mism_cnt  out  CNT_W  number of checked samples with at least one mismatch; saturates.
- smp_cnt  out  CNT_W  number of checked samples (after warm-up); saturates.
- first_idx  out  CNT_W  smp_cnt value at the first failing sample.
- first_lane  out  3  lowest-index failing lane of the first failure.
- first_diff  out  WIDTH  golden XOR first_lane data at the first failure.
- state  out  2  0 = WARM, 1 = CHECK, 2 = HALT.

Behaviour:
- Reset: on posedge clk with rst_n=0, every output, counter, delay stage and valid bit clears to 0 and state goes to WARM. Reset mid-run discards all in-flight delayed samples.
- Alignment:
  - Lane i is a shift register of depth LANE_DLY[i], carrying data plus a valid bit; it advances every cycle.
  - Lane i's aligned sample is valid when its delayed valid bit is 1.
  - A lane-i sample is compared with the lane-0 sample delivered in the same cycle, when both are valid. If only one is valid, no comparison occurs.
- Compare latency: the aligned compare is registered. fail and fail_vec assert 1 cycle after the aligned mismatching sample appears.
- A lane mismatches when it is unmasked, aligned-valid, and its data differs from golden in any bit.
- State machine:
  - WARM: count aligned-valid golden samples. After WARMUP of them, go to CHECK. If WARMUP=0, enter CHECK directly out of reset.
  - CHECK:
    - Every aligned-valid golden sample increments smp_cnt.
    - A sample with any mismatch increments mism_cnt, sets fail and ORs the failing lanes into fail_vec.
    - At the first mismatch (fail still 0), capture first_idx = smp_cnt (pre-increment), first_lane and first_diff.
    - If stop_on_fail=1 at that cycle, go to HALT.
  - HALT: counters, flags and capture frozen; leave only via reset.
- Simultaneous failing lanes: every failing lane sets its fail_vec bit; first_lane/first_diff use the lowest index.
- Counters saturate at all-ones and never wrap.
- lane_mask and stop_on_fail are sampled each cycle at compare time.
- With NUM_DUT=2 and LANE_DLY=0 the block reduces to an equality check with 1-cycle registered reporting.
- Formal: assert property (fail == 0) inside the wrapper, gated on state != WARM.

Decomposition:
- Package equiv_pkg: state encoding (WARM/CHECK/HALT), lane-index width constant, LANE_DLY field-extract function.
- One sub-module, equiv_delay_line: parametrised WIDTH and DEPTH, carries data+valid, DEPTH=0 acts as a wire. Instantiated once per lane via generate.

Test Plan:
- Equal inputs, NUM_DUT=3, 20 valid samples, WARMUP=2 -> fail=0, smp_cnt=18, state=CHECK.
- LANE_DLY lane1=3, lane1 stimulus fed 3 cycles earlier than the golden-equivalent -> no mismatch. Same stimulus with LANE_DLY=0 -> fail=1 and first_lane=1.
- Lane2 bit 5 flipped on checked sample 4, stop_on_fail=1 -> fail 1 cycle later, first_idx=4, first_lane=2, first_diff=0x20, state=HALT, counters frozen.
- Lanes 1 and 2 both mismatch on one sample, stop_on_fail=0, then 3 further mismatches on lane 1 -> fail_vec=3'b110, first_lane=1, mism_cnt=4.
- lane_mask=3'b100 with lane2 always wrong -> fail=0. Clearing the mask mid-run -> fail on the next aligned sample.
- CNT_W=4, 20 mismatching samples -> mism_cnt=15 saturated. Assert rst_n=0 for 1 cycle mid-run -> all outputs 0, state=WARM.
